wrr_cfg_loader: RTL and testbench
=================================

# wrr_cfg_loader

Configuration controller for the 4-virtual-channel weighted round-robin arbiter. It accepts a new 64-slot priority table over a narrow byte-wide config port and builds it in a shadow register. It checks that every virtual channel gets at least one slot. On success it commits the table to the arbiter's 128-bit `tester_input`-style table bus and issues the one-cycle `init` pulse that makes the arbiter reload.

## Interface
Parameters:
- `BEATS`, 16: config beats per table (4 slots × 2 bits per 8-bit beat; 16 × 8 = 128 bits).
- `REQUIRE_ALL_VC`, 1: if 1, a table with any channel weight of 0 is rejected; if 0, such a table is committed.

Ports:
- `clk0`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `enb`  in  1  global enable; when low, the FSM and all registers hold.
- `cfg_start`  in  1  begin (or restart) a table load.
- `cfg_valid`  in  1  `cfg_data` beat valid.
- `cfg_data`  in  8  four 2-bit slot IDs; bits [1:0] are the lowest slot of the beat.
- `cfg_ready`  out  1  loader accepts a beat this cycle.
- `table_out`  out  128  committed table to the arbiter; slot i is bits [2i+1:2i].
- `init`  out  1  one-cycle reload pulse to the arbiter.
- `busy`  out  1  FSM not in IDLE.
- `cfg_err`  out  1  last load was rejected.
- `weight_vc0..3`  out  7 each  slot count of each channel in the committed table (0..64).

## Operation
- FSM states: IDLE, LOAD, CHECK, COMMIT, ERR.
- IDLE: `cfg_ready`=0. `cfg_start` → LOAD; the beat counter and the four shadow counts clear.
- LOAD:
  - `cfg_ready`=1.
  - Handshake = `cfg_valid & cfg_ready & enb`. Each handshake writes beat k into shadow bits [8k+7:8k] and adds its 4 slot IDs to the shadow counts. k then increments.
  - The handshake at k=15 → CHECK.
- CHECK (one cycle):
  - If `REQUIRE_ALL_VC` and any shadow count is 0 → ERR.
  - Otherwise → COMMIT.
- COMMIT (one cycle): `table_out` ← shadow, `weight_vc*` ← shadow counts, `init`=1, `cfg_err`←0. Next state IDLE.
- ERR (one cycle): `table_out` and the weights are unchanged, `cfg_err`←1, no `init`. Next state IDLE.
- `cfg_err` stays high until the next `cfg_start` is accepted or the next COMMIT.
- `cfg_start` in LOAD aborts and restarts: k=0, shadow counts clear, the partial table is discarded. The same-cycle beat is ignored.
- `cfg_start` in CHECK, COMMIT or ERR is ignored.
- `cfg_valid` outside LOAD is ignored.
- Count arithmetic: 7-bit unsigned; the maximum is 64, so it never overflows.

## Timing
- Reset values:
  - State = IDLE.
  - `table_out` = {16{8'hE4}} (slot i = i mod 4, plain round-robin).
  - `weight_vc0..3` = 16.
  - `init`, `cfg_ready`, `busy`, `cfg_err` = 0.
- `rst` has priority over `enb`. Reset mid-LOAD discards the shadow table, and the committed table returns to its reset value.
- Beat rate: at most 1 beat per cycle. A minimum load is 16 consecutive cycles.
- Commit latency:
  - Final handshake at cycle N.
  - CHECK during cycle N+1.
  - `init`=1 and the new `table_out` are visible during cycle N+2.
  - `busy` falls in cycle N+3.
- `cfg_start` → `busy`: `busy`=1 starting the cycle after the `cfg_start` cycle.
- All outputs are registered. `init` is high for exactly one cycle per successful load.
- `enb` low: no state change and no handshake. A pending `init` is held until `enb` returns; it is never dropped or duplicated.

## Structure
- The shared include file `wrr_defs.v` holds:
  - the state encodings;
  - `NUM_VC`=4 and `NUM_SLOTS`=64;
  - `VCHANEL0..3` = 2'b00..2'b11;
  - `WRR_RESET_TABLE`.
- One sub-module, `wrr_beat_counter`: combinational. It takes an 8-bit beat and outputs four 3-bit per-channel counts (0..4). The loader adds these counts into the shadow accumulators.

## Test plan
- **Reset:** `rst`=1 for 2 cycles → `table_out`=128'hE4E4…E4, `weight_vc*`=16, `init`=0, `cfg_err`=0.
- **Valid load:** 16 beats of 8'h1B (slots 3,2,1,0) back-to-back → `init`=1 exactly 2 cycles after the last beat, `table_out`={16{8'h1B}}, all weights 16.
- **Skewed load:** beats 0–14 = 8'h00, beat 15 = 8'hE4 → weights 61/1/1/1, table committed, `init` pulses once.
- **Rejected load:** all beats 8'h55 (VC1 only), `REQUIRE_ALL_VC`=1 → `cfg_err`=1, no `init`, `table_out` unchanged.
- **Abort and throttle:** `cfg_start` re-asserted after 5 beats, then 16 new beats with `cfg_valid` toggling every other cycle → only the second table is committed, and the weights reflect it.
- **Enable stall:** `enb` dropped for 3 cycles in the COMMIT-pending cycle, and `rst` asserted mid-LOAD in a second run → `init` is delayed exactly 3 cycles and still pulses once; after the reset, outputs are back at their reset values.

Source files
------------

// File: rtl/wrr_cfg_loader_pkg.sv
// -----------------------------------------------------------------------------
// wrr_cfg_loader_pkg
// Shared definitions for the WRR arbiter configuration loader:
//   - table geometry (4 virtual channels, 64 two-bit slots, byte-wide beats)
//   - virtual-channel slot IDs
//   - the plain round-robin reset table and reset weight
//   - the loader FSM state encoding and packed count types
// -----------------------------------------------------------------------------
package wrr_cfg_loader_pkg;

  localparam int NUM_VC         = 4;
  localparam int NUM_SLOTS      = 64;
  localparam int SLOT_W         = 2;
  localparam int BEAT_W         = 8;
  localparam int SLOTS_PER_BEAT = BEAT_W / SLOT_W;
  localparam int TABLE_W        = NUM_SLOTS * SLOT_W;
  localparam int CNT_W          = 7;   // holds 0..64

  localparam logic [SLOT_W-1:0] VCHANEL0 = 2'b00;
  localparam logic [SLOT_W-1:0] VCHANEL1 = 2'b01;
  localparam logic [SLOT_W-1:0] VCHANEL2 = 2'b10;
  localparam logic [SLOT_W-1:0] VCHANEL3 = 2'b11;

  // Slot i = i mod 4: plain round-robin, every channel gets 16 slots.
  localparam logic [TABLE_W-1:0] WRR_RESET_TABLE  = {16{8'hE4}};
  localparam logic [CNT_W-1:0]   WRR_RESET_WEIGHT = 7'd16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // Per-channel slot counts of a single beat (0..4 each).
  typedef logic [NUM_VC-1:0][2:0]       beat_cnt_t;
  // Per-channel slot counts of a whole table (0..64 each).
  typedef logic [NUM_VC-1:0][CNT_W-1:0] vc_cnt_t;

endpackage

// File: rtl/wrr_cfg_loader_beat_counter.sv
// -----------------------------------------------------------------------------
// wrr_beat_counter
// Combinational: counts how many of the four 2-bit slot IDs in one config
// beat belong to each virtual channel.
//   beat   in  8     four slot IDs, bits [1:0] = lowest slot
//   counts out 4x3   counts[v] = number of slots equal to channel v (0..4)
// -----------------------------------------------------------------------------
module wrr_beat_counter
  import wrr_cfg_loader_pkg::*;
(
  input  logic [BEAT_W-1:0] beat,
  output beat_cnt_t         counts
);

  function automatic logic [2:0] hits(input logic [BEAT_W-1:0] b,
                                      input logic [SLOT_W-1:0] id);
    logic [2:0] n;
    n = '0;
    for (int s = 0; s < SLOTS_PER_BEAT; s++) begin
      if (b[s*SLOT_W +: SLOT_W] == id) n = n + 3'd1;
    end
    return n;
  endfunction

  always_comb begin
    counts[0] = hits(beat, VCHANEL0);
    counts[1] = hits(beat, VCHANEL1);
    counts[2] = hits(beat, VCHANEL2);
    counts[3] = hits(beat, VCHANEL3);
  end

endmodule

// File: rtl/wrr_cfg_loader.sv
// -----------------------------------------------------------------------------
// wrr_cfg_loader
// Builds a new 64-slot WRR priority table from byte-wide config beats in a
// shadow register, verifies every channel owns at least one slot, then commits
// it to the arbiter table bus with a one-cycle init pulse.
//   clk0            in   clock, all logic on posedge
//   rst             in   synchronous active-high reset (priority over enb)
//   enb             in   global enable; low = FSM and registers hold
//   cfg_start       in   begin / restart a table load
//   cfg_valid       in   cfg_data beat valid
//   cfg_data        in   four 2-bit slot IDs per beat
//   cfg_ready       out  loader accepts a beat this cycle
//   table_out       out  committed table, slot i = bits [2i+1:2i]
//   init            out  one-cycle arbiter reload pulse
//   busy            out  FSM not in IDLE
//   cfg_err         out  last load was rejected
//   weight_vc0..3   out  per-channel slot counts of the committed table
// -----------------------------------------------------------------------------
module wrr_cfg_loader
  import wrr_cfg_loader_pkg::*;
#(
  parameter int BEATS          = 16,
  parameter bit REQUIRE_ALL_VC = 1'b1
) (
  input  logic               clk0,
  input  logic               rst,
  input  logic               enb,
  input  logic               cfg_start,
  input  logic               cfg_valid,
  input  logic [BEAT_W-1:0]  cfg_data,
  output logic               cfg_ready,
  output logic [TABLE_W-1:0] table_out,
  output logic               init,
  output logic               busy,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   weight_vc0,
  output logic [CNT_W-1:0]   weight_vc1,
  output logic [CNT_W-1:0]   weight_vc2,
  output logic [CNT_W-1:0]   weight_vc3
);

  localparam int KW = $clog2(BEATS);

  state_t             state, state_nxt;
  logic [KW-1:0]      beat_idx;
  logic [TABLE_W-1:0] shadow;
  vc_cnt_t            shadow_cnt;
  beat_cnt_t          beat_cnt;

  logic start_acc, hs, last_beat, any_zero;
  logic init_d, cfg_err_d, busy_d, cfg_ready_d;

  wrr_beat_counter u_beat_counter (
    .beat   (cfg_data),
    .counts (beat_cnt)
  );

  // A start is only honoured in IDLE or LOAD; a start in LOAD wins over the
  // beat presented in the same cycle, which is dropped.
  assign start_acc = enb & cfg_start & ((state == ST_IDLE) | (state == ST_LOAD));
  assign hs        = enb & cfg_valid & cfg_ready & ~cfg_start;
  assign last_beat = hs & (beat_idx == KW'(BEATS - 1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    any_zero = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (shadow_cnt[v] == '0) any_zero = 1'b1;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk0) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (enb) begin
      unique case (state)
        ST_IDLE:   if (cfg_start) state_nxt = ST_LOAD;
        ST_LOAD:   if (cfg_start)      state_nxt = ST_LOAD;
                   else if (last_beat) state_nxt = ST_CHECK;
        ST_CHECK:  state_nxt = (REQUIRE_ALL_VC && any_zero) ? ST_ERR : ST_COMMIT;
        ST_COMMIT: state_nxt = ST_IDLE;
        ST_ERR:    state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // Outputs are registered from next-state decode so they line up with the
  // state they describe. init fires on the CHECK->COMMIT transition only, so
  // with enb low it simply waits and can never repeat.
  always_comb begin
    init_d      = (state == ST_CHECK) && (state_nxt == ST_COMMIT);
    busy_d      = (state_nxt != ST_IDLE);
    cfg_ready_d = (state_nxt == ST_LOAD);
    cfg_err_d   = cfg_err;
    if (start_acc)                                 cfg_err_d = 1'b0;
    if ((state == ST_CHECK) && (state_nxt == ST_ERR)) cfg_err_d = 1'b1;
    if (init_d)                                    cfg_err_d = 1'b0;
  end

  // ---------------- datapath and output registers ----------------
  always_ff @(posedge clk0) begin
    if (rst) begin
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      init       <= 1'b0;
      cfg_err    <= 1'b0;
      table_out  <= WRR_RESET_TABLE;
      weight_vc0 <= WRR_RESET_WEIGHT;
      weight_vc1 <= WRR_RESET_WEIGHT;
      weight_vc2 <= WRR_RESET_WEIGHT;
      weight_vc3 <= WRR_RESET_WEIGHT;
      beat_idx   <= '0;
      shadow_cnt <= '0;
    end else begin
      cfg_ready <= cfg_ready_d;
      busy      <= busy_d;
      init      <= init_d;
      cfg_err   <= cfg_err_d;

      if (start_acc) begin
        beat_idx   <= '0;
        shadow_cnt <= '0;
      end else if (hs) begin
        beat_idx <= beat_idx + KW'(1);
        for (int v = 0; v < NUM_VC; v++) begin
          shadow_cnt[v] <= shadow_cnt[v] + CNT_W'(beat_cnt[v]);
        end
      end

      if (init_d) begin
        table_out  <= shadow;
        weight_vc0 <= shadow_cnt[0];
        weight_vc1 <= shadow_cnt[1];
        weight_vc2 <= shadow_cnt[2];
        weight_vc3 <= shadow_cnt[3];
      end
    end
  end

  // NOTE: the shadow table has no reset: all BEATS entries are rewritten
  // before any commit can read it, so its contents out of reset are irrelevant.
  always_ff @(posedge clk0) begin
    if (hs) shadow[int'(beat_idx)*BEAT_W +: BEAT_W] <= cfg_data;
  end

endmodule

// File: tb/tb_wrr_cfg_loader.sv
module tb_wrr_cfg_loader;

  localparam int BEATS = 16;

  logic         clk0 = 1'b0;
  logic         rst, enb, cfg_start, cfg_valid;
  logic [7:0]   cfg_data;
  logic         cfg_ready, init, busy, cfg_err;
  logic [127:0] table_out;
  logic [6:0]   weight_vc0, weight_vc1, weight_vc2, weight_vc3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk0 = ~clk0;

  wrr_cfg_loader #(.BEATS(BEATS), .REQUIRE_ALL_VC(1'b1)) dut (
    .clk0       (clk0),
    .rst        (rst),
    .enb        (enb),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .table_out  (table_out),
    .init       (init),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .weight_vc0 (weight_vc0),
    .weight_vc1 (weight_vc1),
    .weight_vc2 (weight_vc2),
    .weight_vc3 (weight_vc3)
  );

  // Reference model state: the table the arbiter should currently hold.
  logic [7:0]   beats [BEATS];
  logic [127:0] reset_tbl = {16{8'hE4}};
  logic [127:0] ref_table;
  int           ref_w [4];
  bit           ref_commit;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic model_reset();
    ref_table = reset_tbl;
    for (int v = 0; v < 4; v++) ref_w[v] = 16;
  endtask

  // Slot-level view of the loaded table: count owners of all 64 slots.
  function automatic void model_predict();
    int         cnt [4];
    logic [1:0] slot;
    for (int v = 0; v < 4; v++) cnt[v] = 0;
    for (int i = 0; i < 64; i++) begin
      slot = beats[i/4][2*(i%4) +: 2];
      cnt[slot]++;
    end
    ref_commit = (cnt[0] > 0) && (cnt[1] > 0) && (cnt[2] > 0) && (cnt[3] > 0);
    if (ref_commit) begin
      for (int i = 0; i < 64; i++) ref_table[2*i +: 2] = beats[i/4][2*(i%4) +: 2];
      for (int v = 0; v < 4; v++) ref_w[v] = cnt[v];
    end
  endfunction

  task automatic check_committed(input string tag);
    check({tag, " table"}, table_out, ref_table);
    check({tag, " w0"}, weight_vc0, ref_w[0]);
    check({tag, " w1"}, weight_vc1, ref_w[1]);
    check({tag, " w2"}, weight_vc2, ref_w[2]);
    check({tag, " w3"}, weight_vc3, ref_w[3]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " init"}, init, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " ready"}, cfg_ready, 1'b0);
    check({tag, " err"}, cfg_err, 1'b0);
    check_committed(tag);
  endtask

  task automatic start_load(input string tag);
    cfg_start = 1'b1;
    cfg_valid = 1'b0;
    tick();
    cfg_start = 1'b0;
    check({tag, " start busy"}, busy, 1'b1);
    check({tag, " start ready"}, cfg_ready, 1'b1);
    check({tag, " start err clr"}, cfg_err, 1'b0);
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid and enb.
  // Returns right after the edge that took the final beat.
  task automatic feed(input string tag, input int mode);
    int k      = 0;
    int cyc    = 0;
    int budget = 400;
    bit v, e;
    while (k < BEATS && budget > 0) begin
      case (mode)
        0:       begin v = 1'b1;              e = 1'b1; end
        1:       begin v = (cyc % 2) == 0;    e = 1'b1; end
        default: begin v = 1'($urandom_range(0, 1)); e = ($urandom_range(0, 3) != 0); end
      endcase
      cfg_valid = v;
      enb       = e;
      cfg_data  = v ? beats[k] : 8'($urandom);
      tick();
      if (v && e) k++;
      cyc++;
      budget--;
    end
    cfg_valid = 1'b0;
    enb       = 1'b1;
    if (k < BEATS) check({tag, " feed timeout"}, k, BEATS);
  endtask

  // Called in the CHECK cycle after the final beat.
  task automatic check_result(input string tag);
    check({tag, " check-cycle init"}, init, 1'b0);
    check({tag, " check-cycle busy"}, busy, 1'b1);
    tick();
    check({tag, " init"}, init, ref_commit);
    check({tag, " err"}, cfg_err, !ref_commit);
    check_committed(tag);
    tick();
    check({tag, " init falls"}, init, 1'b0);
    check({tag, " busy falls"}, busy, 1'b0);
    check({tag, " err held"}, cfg_err, !ref_commit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enb = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    model_reset();

    // Reset
    tick(); tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Valid load: 16 x 8'h1B back-to-back
    for (int b = 0; b < BEATS; b++) beats[b] = 8'h1B;
    start_load("valid");
    feed("valid", 0);
    model_predict();
    check_result("valid");

    // Skewed load: weights 61/1/1/1
    for (int b = 0; b < BEATS; b++) beats[b] = (b == BEATS - 1) ? 8'hE4 : 8'h00;
    start_load("skew");
    feed("skew", 0);
    model_predict();
    check("skew w0 61", ref_w[0], 61);
    check_result("skew");

    // Rejected load: VC1 only
    for (int b = 0; b < BEATS; b++) beats[b] = 8'h55;
    start_load("reject");
    feed("reject", 0);
    model_predict();
    check_result("reject");
    tick();
    check("reject err sticky", cfg_err, 1'b1);

    // Abort after 5 beats, then a throttled reload (start clears cfg_err)
    start_load("abort");
    for (int b = 0; b < 5; b++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'h00;
      tick();
    end
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hFF;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    check("abort restart busy", busy, 1'b1);
    for (int b = 0; b < BEATS; b++) beats[b] = 8'($urandom);
    beats[0] = 8'hE4;
    feed("abort", 1);
    model_predict();
    check_result("abort");

    // Enable stall in the COMMIT-pending cycle: init delayed exactly 3 cycles
    for (int b = 0; b < BEATS; b++) beats[b] = 8'($urandom);
    beats[3] = 8'h1B;
    start_load("stall");
    feed("stall", 0);
    model_predict();
    enb = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall init held", init, 1'b0);
      check("stall busy", busy, 1'b1);
    end
    enb = 1'b1;
    tick();
    check("stall init", init, 1'b1);
    check_committed("stall");
    tick();
    check("stall init once", init, 1'b0);
    check("stall busy falls", busy, 1'b0);

    // Reset mid-LOAD: everything returns to reset values
    start_load("midrst");
    for (int b = 0; b < 7; b++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'($urandom);
      tick();
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    check_reset_state("midrst");
    for (int c = 0; c < 3; c++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'($urandom);
      tick();
      check("midrst idle init", init, 1'b0);
      check("midrst idle busy", busy, 1'b0);
    end
    cfg_valid = 1'b0;

    // Randomized loads, some restricted to VC0..2 so they must be rejected
    for (int r = 0; r < 9; r++) begin
      for (int b = 0; b < BEATS; b++) begin
        for (int s = 0; s < 4; s++) begin
          beats[b][2*s +: 2] = (r % 3 == 2) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
        end
      end
      start_load("rand");
      feed("rand", r % 3);
      model_predict();
      check_result("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
